// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker slice.
// Holds the default LFSR length and taps, so the checker and the upstream
// generator cannot disagree, and the checker FSM state encodings.
package prbs_checker_pkg;

  localparam int unsigned     LFSR_N    = 24;
  localparam logic [LFSR_N:1] LFSR_TAPS = 24'hE10000;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_UNUSED = 2'd3
  } state_t;

endpackage

// File: rtl/prbs_checker_lfsr_feedback.sv
// Combinational LFSR feedback: XOR of every history bit selected by TAPS.
// This is the single feedback definition shared with the sequence generator.
// Ports:
//   vec   in  [N:1]  history vector, vec[1] newest
//   fb_c  out 1      predicted next bit
module prbs_checker_lfsr_feedback
  import prbs_checker_pkg::*;
#(
  parameter int unsigned N    = LFSR_N,
  parameter logic [N:1]  TAPS = LFSR_TAPS
) (
  input  logic [N:1] vec,
  output logic       fb_c
);

  assign fb_c = ^(vec & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker for the m-sequence of the upstream LFSR.
// Fills a history register, searches for LOCK_CNT consecutive correct
// predictions, then flywheels on its own prediction and counts bit errors.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bit_in      received sequence bit
//   bit_valid   bit_in is sampled only when high
//   clear       synchronous clear of err_cnt and bit_cnt
//   locked      high exactly while the FSM is in LOCKED
//   err_pulse   one-cycle pulse per error detected while locked
//   err_cnt     saturating error count while locked
//   bit_cnt     saturating checked-bit count while locked
//   state       FSM state, for debug
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int unsigned N          = LFSR_N,
  parameter logic [N:1]  TAPS       = LFSR_TAPS,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned UNLOCK_ERR = 8,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [1:0]       state
);

  localparam int unsigned FILL_W = $clog2(N + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WB_W   = $clog2(WINDOW + 1);
  localparam int unsigned WE_W   = $clog2(UNLOCK_ERR + 1);

  state_t            st;
  logic [N:1]        hist;
  logic [FILL_W-1:0] fill_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [WB_W-1:0]   win_bits;
  logic [WE_W-1:0]   win_err;

  logic              pred_c;
  logic              mismatch_c;
  logic              hist_zero_c;
  logic [FILL_W-1:0] fill_nxt_c;
  logic [RUN_W-1:0]  run_nxt_c;
  logic [WB_W-1:0]   win_bits_nxt_c;
  logic [WE_W-1:0]   win_err_nxt_c;
  logic              err_inc_c;
  logic              bit_inc_c;

  prbs_checker_lfsr_feedback #(
    .N    (N),
    .TAPS (TAPS)
  ) u_feedback (
    .vec  (hist),
    .fb_c (pred_c)
  );

  assign mismatch_c     = bit_in ^ pred_c;
  assign hist_zero_c    = (hist == '0);
  assign fill_nxt_c     = fill_cnt + FILL_W'(1);
  assign run_nxt_c      = run_cnt + RUN_W'(1);
  assign win_bits_nxt_c = win_bits + WB_W'(1);
  assign win_err_nxt_c  = win_err + WE_W'(mismatch_c);
  assign err_inc_c      = bit_valid && (st == ST_LOCKED) && mismatch_c;
  assign bit_inc_c      = bit_valid && (st == ST_LOCKED);

  assign state = st;

  // Synchronisation FSM with history register, lock run and unlock window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      run_cnt   <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (st)
        ST_FILL: begin
          if (bit_valid) begin
            hist     <= {hist[N-1:1], bit_in};
            fill_cnt <= fill_nxt_c;
            if (fill_nxt_c == FILL_W'(N)) begin
              st      <= ST_SEARCH;
              run_cnt <= '0;
            end
          end
        end
        ST_SEARCH: begin
          if (bit_valid) begin
            hist <= {hist[N-1:1], bit_in};
            // All-zero history is not a legal LFSR state; it never counts.
            if (!mismatch_c && !hist_zero_c) begin
              run_cnt <= run_nxt_c;
              if (run_nxt_c == RUN_W'(LOCK_CNT)) begin
                st       <= ST_LOCKED;
                locked   <= 1'b1;
                win_bits <= '0;
                win_err  <= '0;
              end
            end else begin
              run_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (bit_valid) begin
            // Flywheel: a received error must not pollute future predictions.
            hist      <= {hist[N-1:1], pred_c};
            err_pulse <= mismatch_c;
            // The unlock test sees this bit's error before any window rollover.
            if (win_err_nxt_c == WE_W'(UNLOCK_ERR)) begin
              st       <= ST_FILL;
              locked   <= 1'b0;
              hist     <= '0;
              fill_cnt <= '0;
            end else if (win_bits_nxt_c == WB_W'(WINDOW)) begin
              win_bits <= '0;
              win_err  <= '0;
            end else begin
              win_bits <= win_bits_nxt_c;
              win_err  <= win_err_nxt_c;
            end
          end
        end
        default: begin
          st       <= ST_FILL;
          locked   <= 1'b0;
          hist     <= '0;
          fill_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      err_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (err_inc_c && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      if (bit_inc_c && (bit_cnt != '1)) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: an m-sequence source built from the
// recurrence, a queue-based behavioural model compared every cycle, and
// directed scenario checks for lock latency, errors, unlock, reset and clear.
module tb_prbs_checker;

  localparam int unsigned K_N      = 24;
  localparam int unsigned K_LOCK   = 32;
  localparam int unsigned K_UNLOCK = 8;
  localparam int unsigned K_WIN    = 64;
  localparam logic [23:0] K_TAPS   = 24'hE10000;
  localparam longint unsigned K_SAT = 64'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_cnt;
  logic [31:0] bit_cnt;
  logic [1:0]  state;

  prbs_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Tap positions (1 = newest history bit) and the source sequence history.
  int taps[$];
  bit gen_q[$];

  // Behavioural model state: history queue (front = newest), mode 0/1/2.
  bit              hist_q[$];
  int              mode;
  int              fill_n;
  int              run_n;
  int              wbits;
  int              werr;
  longint unsigned m_err;
  longint unsigned m_bits;
  bit              m_pulse;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit xor_taps(input bit q[$]);
    bit p = 1'b0;
    foreach (taps[k]) p ^= q[taps[k]-1];
    return p;
  endfunction

  function automatic bit gen_next();
    bit b = xor_taps(gen_q);
    gen_q.push_front(b);
    void'(gen_q.pop_back());
    return b;
  endfunction

  function automatic void model_reset();
    hist_q = {};
    for (int i = 0; i < int'(K_N); i++) hist_q.push_back(1'b0);
    mode = 0; fill_n = 0; run_n = 0; wbits = 0; werr = 0;
    m_err = 0; m_bits = 0; m_pulse = 1'b0;
  endfunction

  function automatic void shift_in(input bit b);
    hist_q.push_front(b);
    void'(hist_q.pop_back());
  endfunction

  function automatic bit hist_all_zero();
    foreach (hist_q[i]) if (hist_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input bit b, input bit v, input bit clr);
    bit p;
    bit ok;
    bit inc_e = 1'b0;
    bit inc_b = 1'b0;
    m_pulse = 1'b0;
    if (v) begin
      p = xor_taps(hist_q);
      case (mode)
        0: begin
          shift_in(b);
          fill_n++;
          if (fill_n == int'(K_N)) begin mode = 1; run_n = 0; end
        end
        1: begin
          ok = (b == p) && !hist_all_zero();
          shift_in(b);
          run_n = ok ? run_n + 1 : 0;
          if (run_n == int'(K_LOCK)) begin mode = 2; wbits = 0; werr = 0; end
        end
        default: begin
          shift_in(p);
          inc_b = 1'b1;
          if (b != p) begin m_pulse = 1'b1; inc_e = 1'b1; werr++; end
          wbits++;
          if (werr == int'(K_UNLOCK)) begin
            mode = 0; fill_n = 0;
            foreach (hist_q[i]) hist_q[i] = 1'b0;
          end else if (wbits == int'(K_WIN)) begin
            wbits = 0; werr = 0;
          end
        end
      endcase
    end
    if (clr) begin
      m_err = 0; m_bits = 0;
    end else begin
      if (inc_e && m_err < K_SAT) m_err++;
      if (inc_b && m_bits < K_SAT) m_bits++;
    end
  endfunction

  task automatic cyc(input bit b, input bit v, input bit clr);
    @(negedge clk);
    bit_in = b; bit_valid = v; clear = clr;
    @(posedge clk);
    model_step(b, v, clr);
    #1;
    chk("state", 64'(state), 64'(mode));
    chk("locked", 64'(locked), 64'(mode == 2));
    chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
    chk("err_cnt", 64'(err_cnt), m_err);
    chk("bit_cnt", 64'(bit_cnt), m_bits);
  endtask

  // One cycle of the clean source, optionally with an inverted bit.
  task automatic send(input bit v, input bit clr, input bit inv);
    bit b;
    b = v ? (gen_next() ^ inv) : 1'($urandom_range(0, 1));
    cyc(b, v, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bit_valid = 1'b0; clear = 1'b0;
    #1;
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_to_lock(input string tag, input int exp_bits);
    int n = 0;
    while (locked !== 1'b1 && n < 200) begin
      send(1'b1, 1'b0, 1'b0);
      n++;
    end
    chk(tag, 64'(n), 64'(exp_bits));
  endtask

  initial begin
    int pulses;
    int n;
    bit lost;
    bit saw_search;
    bit saw_locked;
    bit nz;

    for (int i = 1; i <= int'(K_N); i++) if (K_TAPS[i-1]) taps.push_back(i);
    do begin
      gen_q = {};
      nz = 1'b0;
      for (int i = 0; i < int'(K_N); i++) begin
        gen_q.push_back(1'($urandom_range(0, 1)));
        nz |= gen_q[i];
      end
    end while (!nz);

    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
    model_reset();
    #10;
    chk("init_locked", 64'(locked), 64'd0);
    chk("init_state", 64'(state), 64'd0);
    chk("init_err_cnt", 64'(err_cnt), 64'd0);
    chk("init_bit_cnt", 64'(bit_cnt), 64'd0);
    chk("init_err_pulse", 64'(err_pulse), 64'd0);
    #10 rst_n = 1'b1;

    // Clean continuous stream: lock after 24 fill + 32 matches.
    count_to_lock("s1_lock_bits", 56);
    for (int i = 0; i < 1000; i++) send(1'b1, 1'b0, 1'b0);
    chk("s1_err_cnt", 64'(err_cnt), 64'd0);
    chk("s1_bit_cnt", 64'(bit_cnt), 64'd1000);

    // Single inverted bit while locked.
    pulses = 0; lost = 1'b0;
    for (int j = 0; j < 200; j++) begin
      send(1'b1, 1'b0, j == 99);
      if (err_pulse === 1'b1) pulses++;
      if (locked !== 1'b1) lost = 1'b1;
    end
    chk("s2_pulses", 64'(pulses), 64'd1);
    chk("s2_err_cnt", 64'(err_cnt), 64'd1);
    chk("s2_lost_lock", 64'(lost), 64'd0);

    // Eight errors inside one window force unlock, then relock.
    send(1'b1, 1'b1, 1'b0);
    n = 0;
    while (wbits != 0 && n < 64) begin send(1'b1, 1'b0, 1'b0); n++; end
    for (int e = 0; e < 8; e++) begin
      repeat ($urandom_range(0, 4)) send(1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b1);
    end
    chk("s3_locked", 64'(locked), 64'd0);
    chk("s3_err_cnt", 64'(err_cnt), 64'd8);
    count_to_lock("s3_relock_bits", 56);

    // Reset asserted mid-lock clears outputs immediately.
    do_reset();

    // All-zero input never locks.
    saw_search = 1'b0; saw_locked = 1'b0;
    for (int i = 0; i < 500; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (state === 2'd1) saw_search = 1'b1;
      if (locked === 1'b1 || state === 2'd2) saw_locked = 1'b1;
    end
    chk("s4_saw_search", 64'(saw_search), 64'd1);
    chk("s4_saw_locked", 64'(saw_locked), 64'd0);
    chk("s4_err_cnt", 64'(err_cnt), 64'd0);

    // Alternating valid: 56 valid bits take 112 cycles.
    do_reset();
    n = 0;
    while (locked !== 1'b1 && n < 300) begin
      n++;
      send(n % 2 == 0, 1'b0, 1'b0);
    end
    chk("s5_lock_cycles", 64'(n), 64'd112);

    // Clear while locked, and clear coinciding with an error.
    for (int i = 0; i < 20; i++) send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0);
    chk("s6_pre_err_cnt", 64'(err_cnt), 64'd1);
    chk("s6_pre_bit_cnt", 64'(bit_cnt), 64'd26);
    send(1'b1, 1'b1, 1'b0);
    chk("s6_clr_err_cnt", 64'(err_cnt), 64'd0);
    chk("s6_clr_bit_cnt", 64'(bit_cnt), 64'd0);
    chk("s6_clr_locked", 64'(locked), 64'd1);
    send(1'b1, 1'b1, 1'b1);
    chk("s6_clr_err_same", 64'(err_cnt), 64'd0);
    chk("s6_clr_err_pulse", 64'(err_pulse), 64'd1);

    // Random valid, errors and clears; later half has dense error bursts.
    for (int k = 0; k < 3000; k++) begin
      int rate;
      rate = (k < 1500) ? 40 : 6;
      send($urandom_range(0, 3) != 0,
           $urandom_range(0, 299) == 0,
           $urandom_range(0, rate - 1) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
